// File: rtl/cpu7_biu_pkg.sv
// rtl/cpu7_biu_pkg.sv - shared constants for the cpu7 BIU arbiter
//
// Purpose: FSM state encodings, the maximum channel count and the
// grant-index width helper shared by cpu7_biu_arb and its picker.
// Ports: none (package).
package cpu7_biu_pkg;

  localparam int BIU_MAX_CH = 8;

  localparam logic [2:0] BIU_ARB_IDLE    = 3'd0;
  localparam logic [2:0] BIU_ARB_RD_REQ  = 3'd1;
  localparam logic [2:0] BIU_ARB_RD_WAIT = 3'd2;
  localparam logic [2:0] BIU_ARB_WR_REQ  = 3'd3;
  localparam logic [2:0] BIU_ARB_WR_WAIT = 3'd4;

  // Index width for NUM_CH channels; never narrower than one bit.
  function automatic int biu_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu7_biu_arb_pick.sv
// rtl/cpu7_biu_arb_pick.sv - combinational rotating priority picker
//
// Purpose: scans the request vector starting at i_ptr (wrapping) and
// returns the first requester. i_ptr tied to 0 gives fixed priority.
// Ports:
//   i_req     - per-channel request vector
//   i_ptr     - index where the scan starts
//   o_gnt_oh  - one-hot grant (all zero when nothing requests)
//   o_gnt_idx - grant index (0 when nothing requests)
module cpu7_biu_arb_pick
  import cpu7_biu_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IW     = 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IW-1:0]     i_ptr,
  output logic [NUM_CH-1:0] o_gnt_oh,
  output logic [IW-1:0]     o_gnt_idx
);

  always_comb begin : p_pick
    // One extra bit so ptr+k (at most 2*NUM_CH-2) cannot overflow before the wrap.
    logic [IW:0] c;
    logic        found;
    c         = '0;
    found     = 1'b0;
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = {1'b0, i_ptr} + (IW+1)'(k);
      if (c >= (IW+1)'(NUM_CH)) c = c - (IW+1)'(NUM_CH);
      if (!found && i_req[c[IW-1:0]]) begin
        found                 = 1'b1;
        o_gnt_oh[c[IW-1:0]]   = 1'b1;
        o_gnt_idx             = c[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/cpu7_biu_arb.sv
// rtl/cpu7_biu_arb.sv - arbiter of NUM_CH core channels onto the single BIU memory port
//
// Purpose: one outstanding transaction at a time, read beats write within a
// channel, per-channel read cancel that still drains the memory side.
// Ports:
//   clk, resetn                      - clock, asynchronous active-low reset
//   ch_rd_req/addr/cancel            - channel read requests (flattened, ch i at [i*AW +: AW])
//   ch_rd_ack, ch_data_valid, ch_data- read accept / data strobe / broadcast data
//   ch_wr_req/addr/data/strb         - channel write requests (flattened)
//   ch_wr_ack, ch_write_done         - write accept / completion
//   biu_rd_*, biu_wr_*               - memory-side request/ack/data handshakes
// Config: define CPU7_BIU_ARB_RR_EN for round-robin grant; default is fixed
// priority with channel 0 highest.
module cpu7_biu_arb
  import cpu7_biu_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int SW     = DW / 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_CH-1:0]    ch_rd_req,
  input  logic [NUM_CH*AW-1:0] ch_rd_addr,
  input  logic [NUM_CH-1:0]    ch_rd_cancel,
  output logic [NUM_CH-1:0]    ch_rd_ack,
  output logic [NUM_CH-1:0]    ch_data_valid,
  output logic [DW-1:0]        ch_data,
  input  logic [NUM_CH-1:0]    ch_wr_req,
  input  logic [NUM_CH*AW-1:0] ch_wr_addr,
  input  logic [NUM_CH*DW-1:0] ch_wr_data,
  input  logic [NUM_CH*SW-1:0] ch_wr_strb,
  output logic [NUM_CH-1:0]    ch_wr_ack,
  output logic [NUM_CH-1:0]    ch_write_done,
  output logic                 biu_rd_req,
  output logic [AW-1:0]        biu_rd_addr,
  input  logic                 biu_rd_ack,
  input  logic                 biu_data_valid,
  input  logic [DW-1:0]        biu_data,
  output logic                 biu_wr_req,
  output logic [AW-1:0]        biu_wr_addr,
  output logic [DW-1:0]        biu_wr_data,
  output logic [SW-1:0]        biu_wr_strb,
  input  logic                 biu_wr_ack,
  input  logic                 biu_write_done
);

  localparam int IW = biu_idx_w(NUM_CH);

  logic [2:0]        r_state, w_next;
  logic [IW-1:0]     r_grant;
  logic              r_cancel;
  logic [AW-1:0]     r_rd_addr, r_wr_addr;
  logic [DW-1:0]     r_wr_data;
  logic [SW-1:0]     r_wr_strb;
  logic [NUM_CH-1:0] w_pick_oh, w_grant_oh;
  logic [IW-1:0]     w_pick_idx, w_ptr;
  logic              w_pick_any, w_pick_rd, w_rd_busy, w_cancel_now, w_kill, w_release;

`ifdef CPU7_BIU_ARB_RR_EN
  logic [IW-1:0] r_rr_ptr;
  assign w_ptr = r_rr_ptr;
`else
  assign w_ptr = '0;
`endif

  cpu7_biu_arb_pick #(.NUM_CH(NUM_CH), .IW(IW)) u_pick (
    .i_req     (ch_rd_req | ch_wr_req),
    .i_ptr     (w_ptr),
    .o_gnt_oh  (w_pick_oh),
    .o_gnt_idx (w_pick_idx)
  );

  assign w_pick_any   = |w_pick_oh;
  assign w_pick_rd    = |(w_pick_oh & ch_rd_req);
  assign w_grant_oh   = {{(NUM_CH-1){1'b0}}, 1'b1} << r_grant;
  assign w_rd_busy    = (r_state == BIU_ARB_RD_REQ) || (r_state == BIU_ARB_RD_WAIT);
  // A cancel in the data cycle must already suppress that cycle's strobe.
  assign w_cancel_now = w_rd_busy & ch_rd_cancel[r_grant];
  assign w_kill       = r_cancel | w_cancel_now;
  assign w_release    = (r_state != BIU_ARB_IDLE) && (w_next == BIU_ARB_IDLE);

  assign biu_rd_addr = r_rd_addr;
  assign biu_wr_addr = r_wr_addr;
  assign biu_wr_data = r_wr_data;
  assign biu_wr_strb = r_wr_strb;

  // Channel strobes are decoded from the state register so an async reset
  // removes them immediately.
  always_comb begin
    w_next        = r_state;
    biu_rd_req    = 1'b0;
    biu_wr_req    = 1'b0;
    ch_rd_ack     = '0;
    ch_data_valid = '0;
    ch_data       = '0;
    ch_wr_ack     = '0;
    ch_write_done = '0;
    case (r_state)
      BIU_ARB_IDLE: begin
        if (w_pick_any) w_next = w_pick_rd ? BIU_ARB_RD_REQ : BIU_ARB_WR_REQ;
      end
      BIU_ARB_RD_REQ: begin
        biu_rd_req = 1'b1;
        ch_data    = biu_data;
        if (biu_rd_ack) begin
          if (!w_kill) ch_rd_ack = w_grant_oh;
          if (biu_data_valid) begin
            if (!w_kill) ch_data_valid = w_grant_oh;
            w_next = BIU_ARB_IDLE;
          end else begin
            w_next = BIU_ARB_RD_WAIT;
          end
        end
      end
      BIU_ARB_RD_WAIT: begin
        ch_data = biu_data;
        if (biu_data_valid) begin
          if (!w_kill) ch_data_valid = w_grant_oh;
          w_next = BIU_ARB_IDLE;
        end
      end
      BIU_ARB_WR_REQ: begin
        biu_wr_req = 1'b1;
        if (biu_wr_ack) begin
          ch_wr_ack = w_grant_oh;
          if (biu_write_done) begin
            ch_write_done = w_grant_oh;
            w_next        = BIU_ARB_IDLE;
          end else begin
            w_next = BIU_ARB_WR_WAIT;
          end
        end
      end
      BIU_ARB_WR_WAIT: begin
        if (biu_write_done) begin
          ch_write_done = w_grant_oh;
          w_next        = BIU_ARB_IDLE;
        end
      end
      default: w_next = BIU_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= BIU_ARB_IDLE;
      r_grant   <= '0;
      r_cancel  <= 1'b0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_strb <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == BIU_ARB_IDLE && w_pick_any) begin
        r_grant <= w_pick_idx;
        if (w_pick_rd) begin
          r_rd_addr <= ch_rd_addr[w_pick_idx*AW +: AW];
        end else begin
          r_wr_addr <= ch_wr_addr[w_pick_idx*AW +: AW];
          r_wr_data <= ch_wr_data[w_pick_idx*DW +: DW];
          r_wr_strb <= ch_wr_strb[w_pick_idx*SW +: SW];
        end
      end
      if (w_cancel_now) r_cancel <= 1'b1;
      // Returning to IDLE zeroes the memory-side fields so an idle port shows all zero.
      if (w_release) begin
        r_grant   <= '0;
        r_cancel  <= 1'b0;
        r_rd_addr <= '0;
        r_wr_addr <= '0;
        r_wr_data <= '0;
        r_wr_strb <= '0;
      end
    end
  end

`ifdef CPU7_BIU_ARB_RR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rr_ptr <= '0;
    end else if (r_state == BIU_ARB_IDLE && w_pick_any) begin
      r_rr_ptr <= (w_pick_idx == IW'(NUM_CH - 1)) ? '0 : w_pick_idx + 1'b1;
    end
  end
`endif

endmodule

// File: doc/cpu7_biu_arb.md
Name: cpu7_biu_arb

Overview:
- Parametrised bus-interface arbiter between NUM_CH core-side requesters (ICU refill, LSU, future DMA/PTW) and the single BIU memory port.
- Uses the same req/ack/data_valid and wr_req/wr_ack/write_done handshake as the existing LSU-BIU interface, on both the channel side and the memory side.
- Serialises transactions: at most one outstanding.
- Adds per-channel read cancel with drain, and selectable fixed-priority or round-robin grant.

Parameters:
- NUM_CH, 2, number of requesting channels (2..8); channel 0 has highest fixed priority.
- AW, 32, address width (`GRLEN` in the core).
- DW, 32, data width.
- SW, DW/8, write strobe width.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- ch_rd_req  in  NUM_CH  per-channel read request, held until ack
- ch_rd_addr  in  NUM_CH*AW  flattened read addresses, channel i at [i*AW +: AW]
- ch_rd_cancel  in  NUM_CH  per-channel pulse; abandons that channel's accepted read
- ch_rd_ack  out  NUM_CH  one-cycle read accept
- ch_data_valid  out  NUM_CH  one-cycle read data strobe
- ch_data  out  DW  read data, broadcast to all channels
- ch_wr_req  in  NUM_CH  per-channel write request, held until ack
- ch_wr_addr  in  NUM_CH*AW  flattened write addresses
- ch_wr_data  in  NUM_CH*DW  flattened write data
- ch_wr_strb  in  NUM_CH*SW  flattened byte strobes
- ch_wr_ack  out  NUM_CH  one-cycle write accept
- ch_write_done  out  NUM_CH  one-cycle write completion
- biu_rd_req  out  1  memory read request
- biu_rd_addr  out  AW  registered read address
- biu_rd_ack  in  1  memory read accept
- biu_data_valid  in  1  memory read data strobe
- biu_data  in  DW  memory read data
- biu_wr_req  out  1  memory write request
- biu_wr_addr  out  AW  registered write address
- biu_wr_data  out  DW  registered write data
- biu_wr_strb  out  SW  registered write strobes
- biu_wr_ack  in  1  memory write accept
- biu_write_done  in  1  memory write completion

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; grant=0; rr_ptr=0; cancel flag=0.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- IDLE:
  - Each channel's candidate is ch_rd_req[i]|ch_wr_req[i]; read beats write within a channel.
  - Winner is registered: grant index, is_write, addr/data/strb latched.
  - Next state is RD_REQ or WR_REQ.
  - Request-to-biu_*_req latency is 1 cycle.
- RD_REQ:
  - biu_rd_req=1 until biu_rd_ack.
  - ch_rd_ack[grant] = biu_rd_ack, combinational, same cycle.
  - On ack, go to RD_WAIT.
  - If biu_rd_ack and biu_data_valid arrive in the same cycle, go directly to IDLE and deliver the data.
- RD_WAIT:
  - ch_data_valid[grant] = biu_data_valid & ~cancel_flag.
  - ch_data = biu_data.
  - Go to IDLE on biu_data_valid.
- Cancel:
  - ch_rd_cancel[grant] in RD_REQ or RD_WAIT sets cancel_flag.
  - The FSM still drains, waiting for ack and data; no channel strobe is emitted.
  - Cancel in the same cycle as biu_data_valid suppresses that strobe.
  - Cancel from a non-granted channel is ignored.
  - cancel_flag clears on return to IDLE.
- WR_REQ:
  - biu_wr_req=1 until biu_wr_ack.
  - ch_wr_ack[grant] mirrors biu_wr_ack.
  - Then go to WR_WAIT.
  - biu_write_done in the ack cycle goes directly to IDLE.
- WR_WAIT: ch_write_done[grant] = biu_write_done; go to IDLE.
- Back-to-back: a channel released in cycle N may be regranted in IDLE at N+1. The minimum idle bubble is 1 cycle.
- No requests pending: stay in IDLE, all outputs 0.
- A memory-side strobe arriving in a state that does not expect it is ignored (protocol error, no state change).
- Async reset mid-transaction returns the FSM to IDLE immediately. No channel strobe is emitted afterwards; the BIU is reset by the same resetn.

Optional Feature:
- Macro: CPU7_BIU_ARB_RR_EN.
- When defined:
  - Round-robin among channels.
  - Search starts at rr_ptr.
  - rr_ptr loads (grant+1) mod NUM_CH on each IDLE grant, wrapping from NUM_CH-1 to 0.
- When undefined:
  - Fixed priority, lowest index wins.
  - rr_ptr logic is absent.

Decomposition:
- Shared package/header cpu7_biu_pkg.vh holds:
  - FSM state encodings: BIU_ARB_IDLE=3'd0, RD_REQ=1, RD_WAIT=2, WR_REQ=3, WR_WAIT=4.
  - The max-channel constant (8).
  - Index width macro: clog2 of NUM_CH.
- One sub-module, cpu7_biu_arb_pick:
  - Combinational priority/rotating picker.
  - Inputs: request vector, rr_ptr.
  - Outputs: one-hot grant and index.

Test Plan:
- NUM_CH=2, ch0 rd_req addr 0x1c000000; biu ack at +2, data 0xdeadbeef at +5 -> biu_rd_req at cycle 1, ch_rd_ack[0] at 2, ch_data_valid[0] with 0xdeadbeef at 5; ch1 outputs stay 0.
- ch0 read and ch1 write 0x1c000100/0x12345678/strb 0xf asserted together, fixed priority -> ch0 read completes first; biu_wr_* carries ch1 values on the following grant; one ch_write_done[1] pulse.
- RR_EN, NUM_CH=4, all four channels requesting reads continuously -> grant order 0,1,2,3,0; no channel granted twice before all others are served.
- ch0 read accepted, ch_rd_cancel[0] pulsed in RD_WAIT, data arrives 3 cycles later -> ch_data_valid stays 0; FSM returns to IDLE; next ch1 request granted normally.
- biu_rd_ack and biu_data_valid in the same cycle -> single-cycle ack plus data strobe; IDLE next cycle.
- resetn low in WR_WAIT -> all outputs 0 asynchronously; after release the FSM is IDLE and a new request is granted with 1-cycle latency.
